store_port_arbiter: RTL

//  Round-robin arbiter sharing one D$ write port among NR_PORTS store-like requesters (port 0: commit queue, others: AMO/CMO write-back).

---
 rtl/store_port_arbiter_if.sv | 37 +++
 rtl/store_port_arbiter.sv | 132 +++++++++++++
 2 files changed

// File: rtl/store_port_arbiter_if.sv
// Bundle of requester-side and D$-side signals for the store port arbiter.
// The arbiter connects through the slave modport; requesters and the cache connect through master.
interface store_port_arbiter_if #(
  parameter int unsigned NR_PORTS = 3,
  parameter int unsigned PLEN     = 56,
  parameter int unsigned XLEN     = 64
);
  localparam int unsigned IdxW = $clog2(NR_PORTS);

  logic                       pause_i;
  logic [NR_PORTS-1:0]        req_i;
  logic [NR_PORTS*PLEN-1:0]   addr_i;
  logic [NR_PORTS*XLEN-1:0]   wdata_i;
  logic [NR_PORTS*XLEN/8-1:0] be_i;
  logic [NR_PORTS*2-1:0]      size_i;
  logic [NR_PORTS-1:0]        gnt_o;
  logic                       cache_req_o;
  logic [PLEN-1:0]            cache_addr_o;
  logic [XLEN-1:0]            cache_wdata_o;
  logic [XLEN/8-1:0]          cache_be_o;
  logic [1:0]                 cache_size_o;
  logic                       cache_gnt_i;
  logic [IdxW-1:0]            owner_o;
  logic                       idle_o;

  modport slave (
    input  pause_i, req_i, addr_i, wdata_i, be_i, size_i, cache_gnt_i,
    output gnt_o, cache_req_o, cache_addr_o, cache_wdata_o, cache_be_o, cache_size_o,
    output owner_o, idle_o
  );

  modport master (
    output pause_i, req_i, addr_i, wdata_i, be_i, size_i, cache_gnt_i,
    input  gnt_o, cache_req_o, cache_addr_o, cache_wdata_o, cache_be_o, cache_size_o,
    input  owner_o, idle_o
  );
endinterface

// File: rtl/store_port_arbiter.sv
// Round-robin arbiter sharing one D$ write port among NR_PORTS store requesters.
// The winner is registered into a single slot that is held on the cache port until granted.
module store_port_arbiter #(
  parameter int unsigned NR_PORTS = 3,
  parameter int unsigned PLEN     = 56,
  parameter int unsigned XLEN     = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  store_port_arbiter_if.slave  bus
);
  localparam int unsigned IdxW = $clog2(NR_PORTS);
  localparam int unsigned BeW  = XLEN / 8;

  typedef enum logic {StEmpty, StFull} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   ptr_q, ptr_d;
  logic [IdxW-1:0]   owner_q, owner_d;
  logic [PLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [BeW-1:0]    be_q, be_d;
  logic [1:0]        size_q, size_d;

  logic              free;
  logic              found;
  logic              accept;
  logic [IdxW-1:0]   sel_idx;
  logic [PLEN-1:0]   sel_addr;
  logic [XLEN-1:0]   sel_wdata;
  logic [BeW-1:0]    sel_be;
  logic [1:0]        sel_size;
  logic [NR_PORTS-1:0] gnt;

  // Rotating priority: ports at or above ptr first, then wrap to the low ports.
  always_comb begin
    found   = 1'b0;
    sel_idx = '0;
    for (int unsigned i = 0; i < NR_PORTS; i++) begin
      if (!found && bus.req_i[i] && (32'(ptr_q) <= i)) begin
        found   = 1'b1;
        sel_idx = IdxW'(i);
      end
    end
    for (int unsigned i = 0; i < NR_PORTS; i++) begin
      if (!found && bus.req_i[i]) begin
        found   = 1'b1;
        sel_idx = IdxW'(i);
      end
    end
  end

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_be    = '0;
    sel_size  = '0;
    for (int unsigned i = 0; i < NR_PORTS; i++) begin
      if (sel_idx == IdxW'(i)) begin
        sel_addr  = bus.addr_i[i*PLEN +: PLEN];
        sel_wdata = bus.wdata_i[i*XLEN +: XLEN];
        sel_be    = bus.be_i[i*BeW +: BeW];
        sel_size  = bus.size_i[i*2 +: 2];
      end
    end
  end

  assign free   = (state_q == StEmpty) || bus.cache_gnt_i;
  // Reset gating keeps gnt low while rst_ni is held, so no requester drops a request into reset.
  assign accept = rst_ni && free && !bus.pause_i && found;

  always_comb begin
    for (int unsigned i = 0; i < NR_PORTS; i++) begin
      gnt[i] = accept && (sel_idx == IdxW'(i));
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    size_d  = size_q;

    unique case (state_q)
      StEmpty: if (accept) state_d = StFull;
      StFull:  if (bus.cache_gnt_i && !accept) state_d = StEmpty;
      default: state_d = StEmpty;
    endcase

    if (accept) begin
      ptr_d   = (sel_idx == IdxW'(NR_PORTS - 1)) ? '0 : sel_idx + 1'b1;
      owner_d = sel_idx;
      addr_d  = sel_addr;
      wdata_d = sel_wdata;
      be_d    = sel_be;
      size_d  = sel_size;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StEmpty;
      ptr_q   <= '0;
      owner_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      size_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      size_q  <= size_d;
    end
  end

  assign bus.gnt_o         = gnt;
  assign bus.cache_req_o   = (state_q == StFull);
  assign bus.cache_addr_o  = addr_q;
  assign bus.cache_wdata_o = wdata_q;
  assign bus.cache_be_o    = be_q;
  assign bus.cache_size_o  = size_q;
  assign bus.owner_o       = owner_q;
  assign bus.idle_o        = (state_q == StEmpty) && !(|bus.req_i);

endmodule
